// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and baud divider helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_state_t;
  // Clocks per oversample tick, rounded to nearest
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return (clk_freq + (baud * oversample) / 2) / (baud * oversample);
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running DIV counter with sync reload, one-clk tick at wrap
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic i_reload,
  output logic o_tick
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  logic [W-1:0] r_cnt;
  logic         w_wrap;
  assign w_wrap = (r_cnt == W'(DIV - 1));
  assign o_tick = w_wrap & ~i_reload;
  // Count 0..DIV-1; a reload restarts the phase so ticks align to the frame
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cnt <= '0;
    else r_cnt <= (i_reload || w_wrap) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with one-entry holding register, framing and overrun flags
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       ovr_clr,
  output logic       busy
);
  localparam int              DIV  = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int              TW   = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]   HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0]   FULL = TW'(OVERSAMPLE - 1);

  uart_state_t   r_state;
  logic [1:0]    r_sync;
  logic [1:0]    r_live;
  logic          r_prev;
  logic          r_armed;
  logic [TW-1:0] r_tcnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          w_rxs;
  logic          w_fall;
  logic          w_start;
  logic          w_tick;
  logic          w_done;
  logic          w_pop;

  assign w_rxs   = r_sync[1];
  assign w_fall  = r_armed & r_prev & ~w_rxs;
  assign w_start = (r_state == IDLE) & w_fall;
  assign w_done  = (r_state == STOP) & w_tick & (r_tcnt == FULL) & w_rxs;
  assign w_pop   = rx_valid & rx_ready;
  assign busy    = (r_state != IDLE);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .i_reload (w_start),
    .o_tick   (w_tick)
  );

  // Synchronize rxd; start edges are only armed once a real high has been seen after reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_sync  <= 2'b11;
      r_prev  <= 1'b1;
      r_live  <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], rxd};
      r_prev  <= w_rxs;
      r_live  <= {r_live[0], 1'b1};
      r_armed <= r_armed | (r_live[1] & w_rxs);
    end

  // Frame FSM: mid-bit sampling on oversample ticks, frame_err pulse on a low stop bit
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state   <= IDLE;
      r_tcnt    <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (r_state)
        IDLE: if (w_fall) begin
          r_state <= START;
          r_tcnt  <= '0;
          r_idx   <= '0;
        end
        START: if (w_tick) begin
          if (r_tcnt == HALF) begin
            r_tcnt  <= '0;
            r_idx   <= '0;
            r_state <= w_rxs ? IDLE : DATA;
          end else r_tcnt <= r_tcnt + 1'b1;
        end
        DATA: if (w_tick) begin
          if (r_tcnt == FULL) begin
            r_tcnt         <= '0;
            r_shift[r_idx] <= w_rxs;
            r_idx          <= r_idx + 1'b1;
            if (r_idx == 3'd7) r_state <= STOP;
          end else r_tcnt <= r_tcnt + 1'b1;
        end
        STOP: if (w_tick) begin
          if (r_tcnt == FULL) begin
            r_tcnt    <= '0;
            r_state   <= w_rxs ? IDLE : BREAK;
            frame_err <= ~w_rxs;
          end else r_tcnt <= r_tcnt + 1'b1;
        end
        BREAK: if (w_rxs) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end

  // Holding register: push when empty or popped this cycle, otherwise drop and flag overrun
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (w_done && (!rx_valid || w_pop)) begin
        rx_data  <= r_shift;
        rx_valid <= 1'b1;
      end else if (w_pop) rx_valid <= 1'b0;
      if (w_done && rx_valid && !w_pop) overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
endmodule
